chip_sr_latch_checker: RTL and testbench

- Parametrised successor to the quad SR-latch chip checker; tests any SR-latch package with N_LATCH channels.
- Drives the DUT chip's active-low set/reset pins through a fixed 8-step vector sequence per channel, samples synchronised Q pins and compares them against expected values.
- Reports pass/fail, a per-channel fail mask and the first failing step.
- Adds a walking-channel mode that exercises one channel at a time while holding the others, to expose crosstalk between channels. The single-generation checker has no such mode.

---
 rtl/chip_tester_pkg.sv | 41 ++++
 rtl/sr_latch_vector_rom.sv | 42 ++++
 rtl/chip_sr_latch_checker.sv | 197 +++++++++++++++++++
 tb/tb_chip_sr_latch_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_tester_pkg.sv
// Shared types and the step vector table for the SR-latch chip checker.
// Step table rows are {s1_n, s2_n, r_n, exp_q}.
package chip_tester_pkg;

  localparam int STEP_W  = 3;
  localparam int N_STEPS = 8;

  localparam logic [STEP_W-1:0] STEP_S2   = 3'd5;
  localparam logic [STEP_W-1:0] STEP_HOLD = 3'd6;
  localparam logic [STEP_W-1:0] STEP_LAST = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    DRIVE,
    SETTLE,
    SAMPLE,
    FINISH,
    DONE
  } state_e;

  typedef struct packed {
    logic s1_n;
    logic s2_n;
    logic r_n;
    logic exp_q;
  } vec_t;

  // exp_q for steps 5 and 6 is replaced per channel by its S2 capability.
  localparam vec_t STEP_TABLE [N_STEPS] = '{
    '{1'b1, 1'b1, 1'b0, 1'b0},
    '{1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b0, 1'b0},
    '{1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b0, 1'b1}
  };

endpackage

// File: rtl/sr_latch_vector_rom.sv
// Per-channel drive and expected vectors for a step/channel/mode.
// Idle channels in walking mode hold 1 if already tested, else 0.
module sr_latch_vector_rom
  import chip_tester_pkg::*;
#(
  parameter int                 N_LATCH     = 4,
  parameter logic [N_LATCH-1:0] DUAL_S_MASK = N_LATCH'(4'b0101),
  parameter int                 CH_W        = 2
) (
  input  logic [STEP_W-1:0]  step_i,
  input  logic [CH_W-1:0]    ch_i,
  input  logic               walk_i,
  output logic [N_LATCH-1:0] s1_n_o,
  output logic [N_LATCH-1:0] s2_n_o,
  output logic [N_LATCH-1:0] r_n_o,
  output logic [N_LATCH-1:0] exp_o
);

  vec_t v;
  logic s2_step;

  // Expand the table row across channels, applying S2 capability and walking holds.
  always_comb begin
    v       = STEP_TABLE[step_i];
    s2_step = (step_i == STEP_S2) || (step_i == STEP_HOLD);
    s1_n_o  = '1;
    s2_n_o  = '1;
    r_n_o   = '1;
    exp_o   = '0;
    for (int i = 0; i < N_LATCH; i++) begin
      if (!walk_i || (CH_W'(i) == ch_i)) begin
        s1_n_o[i] = v.s1_n;
        s2_n_o[i] = v.s2_n | ~DUAL_S_MASK[i];
        r_n_o[i]  = v.r_n;
        exp_o[i]  = s2_step ? DUAL_S_MASK[i] : v.exp_q;
      end else begin
        exp_o[i]  = (CH_W'(i) < ch_i);
      end
    end
  end

endmodule

// File: rtl/chip_sr_latch_checker.sv
// Parametrised SR-latch chip checker with lockstep and walking modes.
// Drives set/reset pins, samples synchronised Q, records failures.
module chip_sr_latch_checker
  import chip_tester_pkg::*;
#(
  parameter int                 N_LATCH       = 4,
  parameter logic [N_LATCH-1:0] DUAL_S_MASK   = N_LATCH'(4'b0101),
  parameter int                 SETTLE_CYCLES = 4
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                Run,
  input  logic                                Mode,
  output logic [N_LATCH-1:0]                  S1_n,
  output logic [N_LATCH-1:0]                  S2_n,
  output logic [N_LATCH-1:0]                  R_n,
  input  logic [N_LATCH-1:0]                  Q,
  input  logic                                DISP_RSLT,
  output logic                                Done,
  output logic                                RSLT,
  output logic [N_LATCH-1:0]                  Fail_mask,
  output logic [STEP_W+$clog2(N_LATCH)-1:0]   Fail_step
);

  localparam int CH_W  = (N_LATCH > 1) ? $clog2(N_LATCH) : 1;
  localparam int FS_W  = STEP_W + $clog2(N_LATCH);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(N_LATCH - 1);

  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("SETTLE_CYCLES must be at least 3");
  end

  state_e             state_q;
  logic               mode_q;
  logic               run_q;
  logic [STEP_W-1:0]  step_q;
  logic [CH_W-1:0]    ch_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_LATCH-1:0] sync1_q;
  logic [N_LATCH-1:0] sync2_q;
  logic [N_LATCH-1:0] s1_q;
  logic [N_LATCH-1:0] s2_q;
  logic [N_LATCH-1:0] r_q;
  logic               done_q;
  logic [N_LATCH-1:0] mask_q;
  logic [FS_W-1:0]    fstep_q;
  logic               first_q;

  logic [N_LATCH-1:0] rom_s1;
  logic [N_LATCH-1:0] rom_s2;
  logic [N_LATCH-1:0] rom_r;
  logic [N_LATCH-1:0] rom_exp;
  logic [N_LATCH-1:0] mism;
  logic               abort;

  sr_latch_vector_rom #(
    .N_LATCH     (N_LATCH),
    .DUAL_S_MASK (DUAL_S_MASK),
    .CH_W        (CH_W)
  ) u_rom (
    .step_i (step_q),
    .ch_i   (ch_q),
    .walk_i (mode_q),
    .s1_n_o (rom_s1),
    .s2_n_o (rom_s2),
    .r_n_o  (rom_r),
    .exp_o  (rom_exp)
  );

  assign mism  = sync2_q ^ rom_exp;
  assign abort = !Run && (state_q != IDLE) && (state_q != DONE);

  // Two-flop synchroniser on the asynchronous latch outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= Q;
      sync2_q <= sync1_q;
    end
  end

  // Test sequencer with registered pin drive and result capture.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      run_q   <= 1'b1;
      step_q  <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      s1_q    <= '1;
      s2_q    <= '1;
      r_q     <= '1;
      done_q  <= 1'b0;
      mask_q  <= '0;
      fstep_q <= '0;
      first_q <= 1'b0;
    end else begin
      run_q <= Run;
      if (abort) begin
        state_q <= IDLE;
        s1_q    <= '1;
        s2_q    <= '1;
        r_q     <= '1;
        done_q  <= 1'b0;
        mask_q  <= '0;
        fstep_q <= '0;
        first_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (Run && !run_q) begin
              state_q <= INIT;
              mode_q  <= Mode;
              mask_q  <= '0;
              fstep_q <= '0;
              first_q <= 1'b0;
              cnt_q   <= '0;
              s1_q    <= {N_LATCH{STEP_TABLE[0].s1_n}};
              s2_q    <= {N_LATCH{STEP_TABLE[0].s2_n}};
              r_q     <= {N_LATCH{STEP_TABLE[0].r_n}};
            end
          end
          INIT: begin
            if (cnt_q == INIT_LAST) begin
              state_q <= DRIVE;
              step_q  <= '0;
              ch_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DRIVE: begin
            s1_q    <= rom_s1;
            s2_q    <= rom_s2;
            r_q     <= rom_r;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
          SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              state_q <= SAMPLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SAMPLE: begin
            mask_q <= mask_q | mism;
            if ((|mism) && !first_q) begin
              first_q <= 1'b1;
              fstep_q <= FS_W'({ch_q, step_q});
            end
            if (step_q != STEP_LAST) begin
              step_q  <= step_q + 1'b1;
              state_q <= DRIVE;
            end else if (mode_q && (ch_q != CH_LAST)) begin
              ch_q    <= ch_q + 1'b1;
              step_q  <= '0;
              state_q <= DRIVE;
            end else begin
              state_q <= FINISH;
            end
          end
          FINISH: begin
            s1_q    <= '1;
            s2_q    <= '1;
            r_q     <= '1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          DONE: begin
            if (!Run) begin
              done_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign S1_n      = s1_q;
  assign S2_n      = s2_q | ~DUAL_S_MASK;
  assign R_n       = r_q;
  assign Done      = done_q;
  assign Fail_mask = mask_q;
  assign Fail_step = fstep_q;
  assign RSLT      = done_q & DISP_RSLT & ~(|mask_q);

endmodule

// File: tb/tb_chip_sr_latch_checker.sv
// Directed bench for chip_sr_latch_checker with a 4-channel latch model.
// Faults: 1=ch2 stuck 0, 2=ch0 set leaks to ch1, 3=ch1 set by ch0's S2.
module tb_chip_sr_latch_checker;

  localparam logic [3:0] DUAL = 4'b0101;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       mode;
  logic [3:0] s1_n;
  logic [3:0] s2_n;
  logic [3:0] r_n;
  logic [3:0] q;
  logic       disp;
  logic       done;
  logic       rslt;
  logic [3:0] fmask;
  logic [4:0] fstep;

  int   errs   = 0;
  int   checks = 0;
  int   fault  = 0;
  int   cyc;

  logic [3:0] lq = '0;
  logic       mset;

  always #5 clk = ~clk;

  chip_sr_latch_checker #(
    .N_LATCH       (4),
    .DUAL_S_MASK   (DUAL),
    .SETTLE_CYCLES (4)
  ) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .Run       (run),
    .Mode      (mode),
    .S1_n      (s1_n),
    .S2_n      (s2_n),
    .R_n       (r_n),
    .Q         (q),
    .DISP_RSLT (disp),
    .Done      (done),
    .RSLT      (rslt),
    .Fail_mask (fmask),
    .Fail_step (fstep)
  );

  always @(s1_n or s2_n or r_n or fault) begin
    for (int i = 0; i < 4; i++) begin
      mset = !s1_n[i] || (DUAL[i] && !s2_n[i]);
      if (fault == 2 && i == 1 && !s1_n[0]) mset = 1'b1;
      if (fault == 3 && i == 1 && !s2_n[0]) mset = 1'b1;
      if (mset) lq[i] = 1'b1;
      else if (!r_n[i]) lq[i] = 1'b0;
    end
  end

  assign q = (fault == 1) ? (lq & 4'b1011) : lq;

  task automatic start_and_wait(input logic m, output int n);
    @(negedge clk);
    mode = m;
    run  = 1'b1;
    n    = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 1000);
  endtask

  task automatic stop_run();
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    mode  = 1'b0;
    disp  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({s1_n, s2_n, r_n} !== 12'hFFF) begin
      errs++;
      $display("FAIL reset_pins: got %h want fff", {s1_n, s2_n, r_n});
    end
    checks++;
    if ({done, rslt, fmask, fstep} !== 11'd0) begin
      errs++;
      $display("FAIL reset_results: got %b want 0", {done, rslt, fmask, fstep});
    end
  endtask

  task automatic test_run_high_at_reset();
    run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (r_n !== 4'hF || done !== 1'b0) begin
      errs++;
      $display("FAIL run_high_no_start: r_n=%h done=%b want f 0", r_n, done);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lockstep_pass();
    fault = 0;
    start_and_wait(1'b0, cyc);
    checks++;
    if (cyc !== 46) begin
      errs++;
      $display("FAIL lock_latency: got %0d want 46", cyc);
    end
    checks++;
    if (rslt !== 1'b1 || fmask !== 4'b0000) begin
      errs++;
      $display("FAIL lock_pass: rslt=%b mask=%b want 1 0000", rslt, fmask);
    end
    checks++;
    if ({s1_n, s2_n, r_n} !== 12'hFFF) begin
      errs++;
      $display("FAIL done_pins: got %h want fff", {s1_n, s2_n, r_n});
    end
    stop_run();
    checks++;
    if (done !== 1'b0) begin
      errs++;
      $display("FAIL done_clear: got %b want 0", done);
    end
  endtask

  task automatic test_stuck_ch2();
    fault = 1;
    start_and_wait(1'b1, cyc);
    checks++;
    if (cyc !== 166) begin
      errs++;
      $display("FAIL walk_latency: got %0d want 166", cyc);
    end
    checks++;
    if (fmask !== 4'b0100 || fstep !== 5'd18 || rslt !== 1'b0) begin
      errs++;
      $display("FAIL stuck_walk: mask=%b step=%0d rslt=%b want 0100 18 0",
               fmask, fstep, rslt);
    end
    stop_run();
    checks++;
    if (fmask !== 4'b0100 || done !== 1'b0) begin
      errs++;
      $display("FAIL mask_retain: mask=%b done=%b want 0100 0", fmask, done);
    end
    start_and_wait(1'b0, cyc);
    checks++;
    if (fmask !== 4'b0100 || fstep !== 5'd2) begin
      errs++;
      $display("FAIL stuck_lock: mask=%b step=%0d want 0100 2", fmask, fstep);
    end
    stop_run();
  endtask

  task automatic test_crosstalk();
    fault = 2;
    start_and_wait(1'b1, cyc);
    checks++;
    if (fmask !== 4'b0010 || fstep !== 5'd2 || rslt !== 1'b0) begin
      errs++;
      $display("FAIL xtalk_walk: mask=%b step=%0d rslt=%b want 0010 2 0",
               fmask, fstep, rslt);
    end
    stop_run();
    start_and_wait(1'b0, cyc);
    checks++;
    if (fmask !== 4'b0000 || rslt !== 1'b1) begin
      errs++;
      $display("FAIL xtalk_lock: mask=%b rslt=%b want 0000 1", fmask, rslt);
    end
    stop_run();
  endtask

  task automatic test_single_s();
    fault = 3;
    start_and_wait(1'b0, cyc);
    checks++;
    if (fmask !== 4'b0010 || fstep !== 5'd5) begin
      errs++;
      $display("FAIL single_s: mask=%b step=%0d want 0010 5", fmask, fstep);
    end
    stop_run();
    fault = 0;
  endtask

  task automatic test_abort();
    fault = 0;
    @(negedge clk);
    mode = 1'b0;
    run  = 1'b1;
    repeat (27) @(posedge clk);
    #1;
    checks++;
    if (r_n !== 4'h0 || s1_n !== 4'hF) begin
      errs++;
      $display("FAIL step4_pins: r_n=%h s1_n=%h want 0 f", r_n, s1_n);
    end
    run = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({s1_n, s2_n, r_n} !== 12'hFFF || done !== 1'b0) begin
      errs++;
      $display("FAIL abort: pins=%h done=%b want fff 0", {s1_n, s2_n, r_n}, done);
    end
    start_and_wait(1'b0, cyc);
    checks++;
    if (cyc !== 46 || rslt !== 1'b1) begin
      errs++;
      $display("FAIL rerun: cyc=%0d rslt=%b want 46 1", cyc, rslt);
    end
    stop_run();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mode = 1'b0;
    run  = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s1_n, s2_n, r_n} !== 12'hFFF || done !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: pins=%h done=%b want fff 0",
               {s1_n, s2_n, r_n}, done);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_disp_gate();
    disp = 1'b0;
    start_and_wait(1'b0, cyc);
    checks++;
    if (done !== 1'b1 || rslt !== 1'b0) begin
      errs++;
      $display("FAIL disp_low: done=%b rslt=%b want 1 0", done, rslt);
    end
    #1;
    disp = 1'b1;
    #1;
    checks++;
    if (rslt !== 1'b1) begin
      errs++;
      $display("FAIL disp_high: rslt=%b want 1", rslt);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_run_high_at_reset();
    test_lockstep_pass();
    test_stuck_ch2();
    test_crosstalk();
    test_single_s();
    test_abort();
    test_async_reset();
    test_disp_gate();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
